// File: rtl/dti_source.sv
// DTI producer: write port -> DEPTH-entry FIFO -> registered valid/ready master port.
// Also counts completed handshakes and flags a consumer that stalls too long.
module dti_source #(
    parameter int DIN     = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DIN-1:0]             wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1):0]   level,
    output logic                       ovf,
    output logic [DIN-1:0]             dout_data,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [CNT_W-1:0]           sent_cnt,
    output logic                       stall
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1) + 1;
    localparam int SW = $clog2(TIMEOUT+1);

    logic [DIN-1:0]   mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      fcnt_q, fcnt_d;
    logic [LW-1:0]    level_q, level_d;
    logic [DIN-1:0]   data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic             acc, hs, load, fifo_ne, push, pop;

    assign full       = (level_q == LW'(DEPTH + 1));
    assign empty      = (level_q == '0);
    assign level      = level_q;
    assign ovf        = ovf_q;
    assign dout_data  = data_q;
    assign dout_valid = valid_q;
    assign sent_cnt   = sent_q;
    assign stall      = (scnt_q == SW'(TIMEOUT));

    always_comb begin
        acc     = wr_en && !full;
        hs      = valid_q && dout_ready;
        load    = !valid_q || hs;
        fifo_ne = (fcnt_q != '0);
        // An empty FIFO lets a write bypass straight into the output register.
        push    = acc && !(load && !fifo_ne);
        pop     = load && fifo_ne;

        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            if (fifo_ne) begin
                valid_d = 1'b1;
                data_d  = mem_q[rptr_q];
            end else if (acc) begin
                valid_d = 1'b1;
                data_d  = wr_data;
            end else begin
                valid_d = 1'b0;
            end
        end

        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

        fcnt_d = fcnt_q;
        if (push && !pop)      fcnt_d = fcnt_q + (AW+1)'(1);
        else if (pop && !push) fcnt_d = fcnt_q - (AW+1)'(1);

        level_d = level_q;
        if (acc && !hs)      level_d = level_q + LW'(1);
        else if (hs && !acc) level_d = level_q - LW'(1);

        ovf_d  = ovf_q | (wr_en && full);
        sent_d = hs ? sent_q + CNT_W'(1) : sent_q;

        // Saturating count of consecutive stalled cycles.
        scnt_d = '0;
        if (valid_q && !dout_ready)
            scnt_d = stall ? scnt_q : scnt_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
            level_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            sent_q  <= '0;
            scnt_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            level_q <= level_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            sent_q  <= sent_d;
            scnt_q  <= scnt_d;
        end
    end
endmodule

// File: tb/tb_dti_source.sv
// Bench for dti_source: directed steps plus random traffic, checked every cycle
// against a queue model of the words held by the block.
module tb_dti_source;
    localparam int DIN = 16, DEPTH = 4, TIMEOUT = 8, CNT_W = 8;
    localparam int CAP = DEPTH + 1;

    logic             clk, rst, wr_en, dout_ready;
    logic [DIN-1:0]   wr_data;
    logic             full, empty, ovf, dout_valid, stall;
    logic [3:0]       level;
    logic [DIN-1:0]   dout_data;
    logic [CNT_W-1:0] sent_cnt;

    dti_source #(.DIN(DIN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .ovf(ovf),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .sent_cnt(sent_cnt), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int q[$];
    bit m_ovf;
    int m_sent, m_scnt, acc_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(dout_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("data", 32'(dout_data), 32'(q[0]));
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == CAP));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("sent_cnt", 32'(sent_cnt), 32'(m_sent % (1 << CNT_W)));
        chk("stall", 32'(stall), 32'(m_scnt == TIMEOUT));
    endtask

    // One clock: drive inputs, advance the model from pre-edge state, check after the edge.
    task automatic step(input logic w, input logic [DIN-1:0] d, input logic r);
        bit vpre, hs, acc, fpre;
        wr_en = w; wr_data = d; dout_ready = r;
        vpre = q.size() > 0;
        fpre = q.size() == CAP;
        hs   = vpre && r;
        acc  = w && !fpre;
        @(posedge clk);
        if (hs) begin q.delete(0); m_sent++; end
        if (acc) begin q.push_back(int'(d)); acc_total++; end
        if (w && fpre) m_ovf = 1'b1;
        if (vpre && !r) m_scnt = (m_scnt + 1 > TIMEOUT) ? TIMEOUT : m_scnt + 1;
        else            m_scnt = 0;
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_sent = 0; m_scnt = 0; acc_total = 0;
    endtask

    initial begin
        int nw;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; dout_ready = 1'b0;
        model_reset();
        #2;
        check_all();
        chk("rst_data", 32'(dout_data), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // single word straight through
        step(1'b1, 16'h00A5, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        chk("single_sent", 32'(sent_cnt), 32'd1);

        // fill while stalled, overflow, then drain
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, DIN'(i), 1'b0);
            chk("hold_data", 32'(dout_data), 32'h1);
        end
        chk("ovf_set", 32'(ovf), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // streaming: one word per cycle, level stays 1
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DIN'(16'h100 + i), 1'b1);
            chk("stream_level", 32'(level), 32'd1);
        end
        step(1'b0, '0, 1'b1);

        // write at full concurrent with handshake is rejected
        for (int i = 0; i < 5; i++) step(1'b1, DIN'(16'h200 + i), 1'b0);
        step(1'b1, 16'h02FF, 1'b1);
        chk("full_hs_level", 32'(level), 32'd4);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // random traffic
        nw = 0;
        for (int c = 0; c < 4000 && nw < 1000; c++) begin
            logic w;
            w = ($urandom % 4) != 0;
            if (w) nw++;
            step(w, DIN'($urandom), 1'($urandom % 2));
        end
        chk("rand_writes", 32'(nw), 32'd1000);
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, '0, 1'b1);
        chk("drained", 32'(empty), 32'd1);
        chk("sent_vs_acc", 32'(sent_cnt), 32'(acc_total % (1 << CNT_W)));

        // stall detection
        step(1'b1, 16'hBEEF, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, '0, 1'b0);
        chk("stall_pre", 32'(stall), 32'd0);
        step(1'b0, '0, 1'b0);
        chk("stall_hi", 32'(stall), 32'd1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("stall_lo", 32'(stall), 32'd0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) step(1'b1, DIN'(16'h300 + i), 1'b0);
        chk("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b1, 16'h0077, 1'b0);
        chk("post_rst_data", 32'(dout_data), 32'h77);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
